// File: rtl/prime_sieve_pkg.sv
// Shared types and sizing helpers for the multi-cycle prime sieve engine.
package prime_sieve_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      OUTER = 3'd2,
      MARK  = 3'd3,
      COUNT = 3'd4,
      DONE  = 3'd5
   } sieve_state_t;

   localparam int DEFAULT_W = 8;

   // Table depth for a given value width.
   function automatic int sieve_depth(input int w);
      return 32'd1 << w;
   endfunction

endpackage

// File: rtl/prime_sieve_bitmap.sv
// Primality bitmap: N flops with bulk init, single-bit clear and two
// asynchronous read ports (sieve walker and query path).
module prime_sieve_bitmap
   import prime_sieve_pkg::*;
#(
   parameter int W = DEFAULT_W
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init,
   input  logic         clr,
   input  logic [W-1:0] clr_idx,
   input  logic [W-1:0] fsm_idx,
   input  logic [W-1:0] q_idx,
   output logic         fsm_bit,
   output logic         q_bit
);

   localparam int N = sieve_depth(W);
   localparam logic [N-1:0] INIT_PATTERN = {{(N-2){1'b1}}, 2'b00};

   logic [N-1:0] bits_r;

   // Bitmap storage; bulk init wins over a clear (they never overlap in practice).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_r <= '0;
      end else if (init) begin
         bits_r <= INIT_PATTERN;
      end else if (clr) begin
         bits_r[clr_idx] <= 1'b0;
      end else begin
         bits_r <= bits_r;
      end
   end

   assign fsm_bit = bits_r[fsm_idx];
   assign q_bit   = bits_r[q_idx];

endmodule

// File: rtl/prime_sieve_engine.sv
// Sieve of Eratosthenes engine: one marking operation per clock, prime count,
// and a valid/ready query port with a one-cycle registered response.
module prime_sieve_engine
   import prime_sieve_pkg::*;
#(
   parameter int W = DEFAULT_W
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         table_valid,
   output logic [W:0]   prime_count,
   input  logic         q_valid,
   output logic         q_ready,
   input  logic [W-1:0] q_num,
   output logic         r_valid,
   output logic [W-1:0] r_num,
   output logic         r_is_prime
);

   localparam int N = sieve_depth(W);
   localparam logic [W:0]     ONE_I   = (W+1)'(32'd1);
   localparam logic [W:0]     TWO_I   = (W+1)'(32'd2);
   localparam logic [W:0]     LAST_I  = (W+1)'(N - 1);
   localparam logic [W+1:0]   LAST_J  = (W+2)'(N - 1);
   localparam logic [2*W+1:0] LAST_SQ = (2*W+2)'(N - 1);

   sieve_state_t   state_r, state_s;
   logic [W:0]     i_r, i_s, j_r, j_s, k_r, k_s, acc_r, acc_s;
   logic [W:0]     prime_count_r, prime_count_s;
   logic           table_valid_r, table_valid_s;
   logic           busy_r, done_r;
   logic           r_valid_r, r_is_prime_r;
   logic [W-1:0]   r_num_r;
   logic           init_s, clr_s, fsm_bit_s, q_bit_s, q_accept_s;
   logic [W-1:0]   fsm_idx_s;
   logic [2*W+1:0] i_wide_s, sq_s;
   logic [W+1:0]   j_next_s;

   // Wide square so the termination compare cannot wrap.
   assign i_wide_s   = {{(W+1){1'b0}}, i_r};
   assign sq_s       = i_wide_s * i_wide_s;
   assign j_next_s   = {1'b0, j_r} + {1'b0, i_r};
   assign fsm_idx_s  = (state_r == COUNT) ? k_r[W-1:0] : i_r[W-1:0];
   assign q_accept_s = q_valid & q_ready;

   prime_sieve_bitmap #(.W(W)) u_bitmap (
      .clk     (clk),
      .rst_n   (rst_n),
      .init    (init_s),
      .clr     (clr_s),
      .clr_idx (j_r[W-1:0]),
      .fsm_idx (fsm_idx_s),
      .q_idx   (q_num),
      .fsm_bit (fsm_bit_s),
      .q_bit   (q_bit_s)
   );

   // Next-state, index and counter logic for the build sequence.
   always_comb begin
      state_s       = state_r;
      i_s           = i_r;
      j_s           = j_r;
      k_s           = k_r;
      acc_s         = acc_r;
      prime_count_s = prime_count_r;
      table_valid_s = table_valid_r;
      init_s        = 1'b0;
      clr_s         = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s       = INIT;
               table_valid_s = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         INIT: begin
            init_s  = 1'b1;
            i_s     = TWO_I;
            state_s = OUTER;
         end
         OUTER: begin
            if (sq_s > LAST_SQ) begin
               state_s = COUNT;
               k_s     = '0;
               acc_s   = '0;
            end else if (fsm_bit_s) begin
               j_s     = sq_s[W:0];
               state_s = MARK;
            end else begin
               i_s = i_r + ONE_I;
            end
         end
         MARK: begin
            clr_s = 1'b1;
            if (j_next_s <= LAST_J) begin
               j_s = j_next_s[W:0];
            end else begin
               i_s     = i_r + ONE_I;
               state_s = OUTER;
            end
         end
         COUNT: begin
            acc_s = acc_r + {{W{1'b0}}, fsm_bit_s};
            if (k_r == LAST_I) begin
               state_s = DONE;
            end else begin
               k_s = k_r + ONE_I;
            end
         end
         DONE: begin
            prime_count_s = acc_r;
            table_valid_s = 1'b1;
            state_s       = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, indices, status and query response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         i_r           <= '0;
         j_r           <= '0;
         k_r           <= '0;
         acc_r         <= '0;
         prime_count_r <= '0;
         table_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         r_valid_r     <= 1'b0;
         r_num_r       <= '0;
         r_is_prime_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         i_r           <= i_s;
         j_r           <= j_s;
         k_r           <= k_s;
         acc_r         <= acc_s;
         prime_count_r <= prime_count_s;
         table_valid_r <= table_valid_s;
         busy_r        <= (state_s != IDLE);
         done_r        <= (state_s == DONE);
         r_valid_r     <= q_accept_s;
         if (q_accept_s) begin
            r_num_r      <= q_num;
            r_is_prime_r <= q_bit_s;
         end else begin
            r_num_r      <= r_num_r;
            r_is_prime_r <= r_is_prime_r;
         end
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign table_valid = table_valid_r;
   assign prime_count = prime_count_r;
   assign q_ready     = table_valid_r & ~busy_r;
   assign r_valid     = r_valid_r;
   assign r_num       = r_num_r;
   assign r_is_prime  = r_is_prime_r;

endmodule

// File: tb/tb_prime_sieve_engine.sv
// Self-checking bench: W=4 and W=8 engines against an arithmetic primality model.
module tb_prime_sieve_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start4, busy4, done4, tv4, qv4, qr4, rv4, rp4;
   logic [4:0] pc4;
   logic [3:0] qn4, rn4;
   logic       start8, busy8, done8, tv8, qv8, qr8, rv8, rp8;
   logic [8:0] pc8;
   logic [7:0] qn8, rn8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prime_sieve_engine #(.W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
      .table_valid(tv4), .prime_count(pc4), .q_valid(qv4), .q_ready(qr4),
      .q_num(qn4), .r_valid(rv4), .r_num(rn4), .r_is_prime(rp4)
   );

   prime_sieve_engine #(.W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
      .table_valid(tv8), .prime_count(pc8), .q_valid(qv8), .q_ready(qr8),
      .q_num(qn8), .r_valid(rv8), .r_num(rn8), .r_is_prime(rp8)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit ref_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int ref_count(input int w);
      int cnt = 0;
      for (int n = 0; n < (1 << w); n++) cnt += int'(ref_prime(n));
      return cnt;
   endfunction

   // One INIT cycle, one cycle per candidate i visited, one per multiple struck,
   // one per table entry counted, one DONE cycle.
   function automatic int ref_latency(input int w);
      int n = 1 << w;
      int outer = 0;
      int marks = 0;
      for (int i = 2; ; i++) begin
         outer++;
         if (i * i > n - 1) break;
         if (ref_prime(i)) begin
            for (int j = i * i; j <= n - 1; j += i) marks++;
         end
      end
      return 1 + outer + marks + n + 1;
   endfunction

   function automatic logic [31:0] get_done(input int w);
      return (w == 4) ? {31'd0, done4} : {31'd0, done8};
   endfunction
   function automatic logic [31:0] get_busy(input int w);
      return (w == 4) ? {31'd0, busy4} : {31'd0, busy8};
   endfunction
   function automatic logic [31:0] get_tv(input int w);
      return (w == 4) ? {31'd0, tv4} : {31'd0, tv8};
   endfunction
   function automatic logic [31:0] get_qr(input int w);
      return (w == 4) ? {31'd0, qr4} : {31'd0, qr8};
   endfunction
   function automatic logic [31:0] get_rv(input int w);
      return (w == 4) ? {31'd0, rv4} : {31'd0, rv8};
   endfunction
   function automatic logic [31:0] get_rp(input int w);
      return (w == 4) ? {31'd0, rp4} : {31'd0, rp8};
   endfunction
   function automatic logic [31:0] get_rn(input int w);
      return (w == 4) ? {28'd0, rn4} : {24'd0, rn8};
   endfunction
   function automatic logic [31:0] get_pc(input int w);
      return (w == 4) ? {27'd0, pc4} : {23'd0, pc8};
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 4) start4 = v;
      else start8 = v;
   endtask

   task automatic set_query(input int w, input logic v, input int n);
      if (w == 4) begin
         qv4 = v;
         qn4 = n[3:0];
      end else begin
         qv8 = v;
         qn8 = n[7:0];
      end
   endtask

   // Start a build (optionally with a same-edge query and a stray mid-build start)
   // and follow it to completion.
   task automatic do_build(input int w, input int mid_start, input bit with_query, input int qnum);
      int lat = 0;
      int pulses = 0;
      int c = 1;
      bit stop = 1'b0;
      @(negedge clk);
      set_start(w, 1'b1);
      if (with_query) set_query(w, 1'b1, qnum);
      @(negedge clk);
      set_start(w, 1'b0);
      set_query(w, 1'b0, 0);
      if (with_query) begin
         check_val("same_edge_rvalid", get_rv(w), 32'd1);
         check_val("same_edge_rnum", get_rn(w), qnum);
         check_val("same_edge_prime", get_rp(w), {31'd0, ref_prime(qnum)});
         check_val("same_edge_qready", get_qr(w), 32'd0);
      end
      check_val("build_busy", get_busy(w), 32'd1);
      while (!stop) begin
         if (get_done(w) == 32'd1) begin
            pulses++;
            if (lat == 0) lat = c;
         end
         if (mid_start != 0 && c == mid_start) set_start(w, 1'b1);
         else set_start(w, 1'b0);
         if ((lat != 0 && c >= lat + 1) || c >= 4000) begin
            stop = 1'b1;
         end else begin
            @(negedge clk);
            c++;
         end
      end
      check_val("build_latency", lat, ref_latency(w));
      check_val("done_pulses", pulses, 32'd1);
      check_val("idle_busy", get_busy(w), 32'd0);
      check_val("table_valid", get_tv(w), 32'd1);
      check_val("q_ready", get_qr(w), 32'd1);
      check_val("prime_count", get_pc(w), ref_count(w));
   endtask

   task automatic query_one(input int w, input int n, input bit spec_prime);
      @(negedge clk);
      set_query(w, 1'b1, n);
      @(negedge clk);
      set_query(w, 1'b0, 0);
      check_val("q_rvalid", get_rv(w), 32'd1);
      check_val("q_rnum", get_rn(w), n);
      check_val("q_prime_model", get_rp(w), {31'd0, ref_prime(n)});
      check_val("q_prime_spec", get_rp(w), {31'd0, spec_prime});
   endtask

   initial begin
      int rv_seen = 0;
      int last_num = 0;
      bit pend = 1'b0;

      rst_n = 1'b0;
      start4 = 1'b0; start8 = 1'b0;
      qv4 = 1'b0; qv8 = 1'b0; qn4 = 4'd0; qn8 = 8'd0;

      // Reset, then idle with queries offered that must not be accepted.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      qv4 = 1'b1; qn4 = 4'd3;
      qv8 = 1'b1; qn8 = 8'd3;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         rv_seen += int'(rv4) + int'(rv8);
      end
      qv4 = 1'b0; qv8 = 1'b0;
      check_val("rst_rvalid_seen", rv_seen, 32'd0);
      check_val("rst_busy", {31'd0, busy4 | busy8}, 32'd0);
      check_val("rst_tv", {31'd0, tv4 | tv8}, 32'd0);
      check_val("rst_qready", {31'd0, qr4 | qr8}, 32'd0);
      check_val("rst_pc4", {27'd0, pc4}, 32'd0);
      check_val("rst_pc8", {23'd0, pc8}, 32'd0);

      // W=4 build: fixed latency from the spec and 6 primes.
      do_build(4, 0, 1'b0, 0);
      check_val("w4_latency_const", ref_latency(4), 32'd30);
      check_val("w4_count_const", {27'd0, pc4}, 32'd6);

      // W=4 back-to-back sweep of every value.
      for (int n = 0; n <= 16; n++) begin
         @(negedge clk);
         if (n > 0) begin
            check_val("sweep_rvalid", {31'd0, rv4}, 32'd1);
            check_val("sweep_rnum", {28'd0, rn4}, n - 1);
            check_val("sweep_prime", {31'd0, rp4}, {31'd0, ref_prime(n - 1)});
         end
         if (n < 16) set_query(4, 1'b1, n);
         else set_query(4, 1'b0, 0);
      end
      @(negedge clk);
      check_val("sweep_rvalid_drop", {31'd0, rv4}, 32'd0);
      check_val("sweep_rnum_hold", {28'd0, rn4}, 32'd15);

      // W=8 build and directed queries.
      do_build(8, 0, 1'b0, 0);
      check_val("w8_count_const", {23'd0, pc8}, 32'd54);
      query_one(8, 251, 1'b1);
      query_one(8, 255, 1'b0);
      query_one(8, 1, 1'b0);
      query_one(8, 0, 1'b0);
      query_one(8, 169, 1'b0);
      query_one(8, 2, 1'b1);
      last_num = 2;

      // W=8 random queries with random gaps; responses hold between accepts.
      for (int t = 0; t <= 60; t++) begin
         @(negedge clk);
         check_val("rnd_rvalid", {31'd0, rv8}, {31'd0, pend});
         check_val("rnd_rnum", {24'd0, rn8}, last_num);
         check_val("rnd_prime", {31'd0, rp8}, {31'd0, ref_prime(last_num)});
         pend = (t < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (pend) begin
            last_num = int'($urandom_range(0, 255));
            set_query(8, 1'b1, last_num);
         end else begin
            set_query(8, 1'b0, int'($urandom_range(0, 255)));
         end
      end

      // Stray start during MARK is ignored; then start alongside a query of 7.
      do_build(4, 4, 1'b0, 0);
      do_build(4, 0, 1'b1, 7);

      // Reset asserted mid-build clears everything at once.
      @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (9) @(negedge clk);
      check_val("pre_abort_busy", {31'd0, busy8}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", {31'd0, busy8}, 32'd0);
      check_val("abort_done", {31'd0, done8}, 32'd0);
      check_val("abort_tv", {31'd0, tv8 | tv4}, 32'd0);
      check_val("abort_pc", {23'd0, pc8}, 32'd0);
      check_val("abort_rvalid", {31'd0, rv8}, 32'd0);
      check_val("abort_rnum", {24'd0, rn8}, 32'd0);
      check_val("abort_prime", {31'd0, rp8}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_build(8, 0, 1'b0, 0);
      query_one(8, 251, 1'b1);
      query_one(8, 169, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
